// File: rtl/div_pkg.sv
// div_pkg: shared FSM/result-kind enums, default width and the two's-complement
// magnitude helper used by the multi-cycle divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 16;
    localparam int DIV_MAX_W         = 64;

    typedef enum logic [1:0] {IDLE, INIT, ITER, FIX} div_state_e;

    typedef enum logic [1:0] {KIND_NORM, KIND_DBZ, KIND_OVF, KIND_EARLY} div_kind_e;

    // Works for any width up to DIV_MAX_W: the low bits of a 64-bit negate
    // equal the narrow negate, so callers just truncate the result.
    function automatic logic [DIV_MAX_W-1:0] twos_mag(input logic [DIV_MAX_W-1:0] v,
                                                      input logic                 neg);
        return neg ? (~v + DIV_MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// div_restoring_step: one combinational restoring-division iteration
// (shift in the next dividend bit, trial-subtract the divisor, restore on borrow).
module div_restoring_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem_in < dvs_mag always holds, so a non-negative trial fits in WIDTH bits
    // and the extra MSB is a clean borrow indicator.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        trial   = shifted - {1'b0, dvs_mag};
        if (trial[WIDTH]) begin
            rem_out = shifted[WIDTH-1:0];
            q_bit   = 1'b0;
        end else begin
            rem_out = trial[WIDTH-1:0];
            q_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle signed/unsigned restoring divider with dbz/overflow flags.
// Optional macro DIV_EARLY_TERM_EN: finish in two cycles when |a| < |b|.
module div_unit
    import div_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH_DEFAULT,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES  = '1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             v_q, v_d;

    div_kind_e        kind_q, kind_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] prem_q, prem_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] fix_q, fix_r;

    div_restoring_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem_q),
        .dvd_bit (dvd_q[WIDTH-1]),
        .dvs_mag (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        a_neg = mode_q & a_q[WIDTH-1];
        b_neg = mode_q & b_q[WIDTH-1];
        a_mag = WIDTH'(twos_mag(DIV_MAX_W'(a_q), a_neg));
        b_mag = WIDTH'(twos_mag(DIV_MAX_W'(b_q), b_neg));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        z_d         = z_q;
        n_d         = n_q;
        v_d         = v_q;
        kind_d      = kind_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        fix_q       = '0;
        fix_r       = '0;

        case (state_q)
            // A start coinciding with the done pulse is dropped; the caller
            // re-presents it one cycle later.
            IDLE: begin
                if (start && !done_q) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = signed_mode;
                    state_d = INIT;
                end
            end
            INIT: begin
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                dvd_d   = a_mag;
                dvs_d   = b_mag;
                prem_d  = '0;
                cnt_d   = CNT_W'(WIDTH);
                kind_d  = KIND_NORM;
                state_d = ITER;
                if (b_q == '0) begin
                    kind_d  = KIND_DBZ;
                    state_d = FIX;
                end else if (mode_q && (a_q == MIN_V) && (b_q == ONES)) begin
                    kind_d  = KIND_OVF;
                    state_d = FIX;
                end
`ifdef DIV_EARLY_TERM_EN
                else if (a_mag < b_mag) begin
                    kind_d  = KIND_EARLY;
                    state_d = FIX;
                end
`endif
            end
            // Quotient bits shift into the dividend register as it empties.
            ITER: begin
                prem_d = step_rem;
                dvd_d  = {dvd_q[WIDTH-2:0], step_q};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dbz_d   = 1'b0;
                v_d     = 1'b0;
                fix_q   = WIDTH'(twos_mag(DIV_MAX_W'(dvd_q), qneg_q));
                fix_r   = WIDTH'(twos_mag(DIV_MAX_W'(prem_q), rneg_q));
                case (kind_q)
                    KIND_DBZ: begin
                        fix_q = ONES;
                        fix_r = a_q;
                        dbz_d = 1'b1;
                        v_d   = 1'b1;
                    end
                    KIND_OVF: begin
                        fix_q = MIN_V;
                        fix_r = '0;
                        v_d   = 1'b1;
                    end
                    KIND_EARLY: begin
                        fix_q = '0;
                        fix_r = a_q;
                    end
                    default: ;
                endcase
                quotient_d  = fix_q;
                remainder_d = fix_r;
                z_d         = (fix_q == '0);
                n_d         = fix_q[WIDTH-1];
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            z_q         <= z_d;
            n_q         <= n_d;
            v_q         <= v_d;
        end
    end

    // Working datapath registers are always loaded before use, so no reset.
    always_ff @(posedge clk) begin
        kind_q <= kind_d;
        a_q    <= a_d;
        b_q    <= b_d;
        mode_q <= mode_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
        dvd_q  <= dvd_d;
        dvs_q  <= dvs_d;
        prem_q <= prem_d;
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign dbz       = dbz_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign C         = 1'b0;
    assign V         = v_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed literal cases plus randomized start traffic for div_unit,
// checked every cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_div_unit;

    localparam int W = 16;
    localparam logic [W-1:0] MINV = 16'h8000;
`ifdef DIV_EARLY_TERM_EN
    localparam int ET_LAT = 2;
`else
    localparam int ET_LAT = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, dbz, Z, N, C, V;

    int n_chk  = 0;
    int n_fail = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .dbz         (dbz),
        .Z           (Z),
        .N           (N),
        .C           (C),
        .V           (V)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         z;
        logic         n;
        logic         v;
    } res_t;

    function automatic res_t ref_div(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic sm);
        res_t o;
        int   sa, sb;
        sa    = int'($signed(ra));
        sb    = int'($signed(rb));
        o     = '0;
        if (rb == '0) begin
            o.q = '1; o.r = ra; o.dbz = 1'b1; o.v = 1'b1;
        end else if (sm && sa == -(1 << (W - 1)) && sb == -1) begin
            o.q = MINV; o.r = '0; o.v = 1'b1;
        end else if (sm) begin
            o.q = W'(sa / sb);
            o.r = W'(sa % sb);
        end else begin
            o.q = ra / rb;
            o.r = ra % rb;
        end
        o.z = (o.q == '0);
        o.n = o.q[W-1];
        return o;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic sm);
`ifdef DIV_EARLY_TERM_EN
        int sa, sb, ma, mb;
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        ma = sm ? ((sa < 0) ? -sa : sa) : int'(ra);
        mb = sm ? ((sb < 0) ? -sb : sb) : int'(rb);
`endif
        if (rb == '0) return 2;
        if (sm && ra == MINV && rb == '1) return 2;
`ifdef DIV_EARLY_TERM_EN
        if (ma < mb) return 2;
`endif
        return W + 2;
    endfunction

    // Model: which edges accept a start, when each result lands, what is held.
    int   cyc    = 0;
    int   due    = 0;
    logic pend   = 1'b0;
    logic m_done = 1'b0;
    res_t m_res  = '0;
    res_t m_hold = '0;

    always @(posedge clk or negedge rst) begin
        logic acc;
        if (!rst) begin
            pend   = 1'b0;
            m_done = 1'b0;
            m_hold = '0;
        end else begin
            cyc++;
            acc    = start && !pend && !m_done;
            m_done = 1'b0;
            if (pend && cyc == due) begin
                m_done = 1'b1;
                pend   = 1'b0;
                m_hold = m_res;
            end
            if (acc) begin
                pend  = 1'b1;
                m_res = ref_div(a, b, signed_mode);
                due   = cyc + ref_lat(a, b, signed_mode);
            end
        end
    end

    always @(negedge clk) begin
        logic [2*W+6:0] act, exp;
        act = {quotient, remainder, done, busy, dbz, Z, N, C, V};
        exp = {m_hold.q, m_hold.r, m_done, pend, m_hold.dbz, m_hold.z, m_hold.n, 1'b0, m_hold.v};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL cycle_model t=%0t got q/r/done/busy/dbz/Z/N/C/V=%h required=%h", $time, act, exp);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", nm, got, req);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || done) && k < 60) begin
            @(posedge clk); #2;
            k++;
        end
        if (k >= 60) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Runs one op; optionally injects a second start mid-operation.
    task automatic run_lit(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic sm, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic [3:0] eflags, input int elat, input bit intrude);
        int lat;
        bit got;
        wait_idle();
        start = 1'b1; a = ta; b = tb_; signed_mode = sm;
        @(posedge clk); #2;
        start = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = i;
                got = 1'b1;
                break;
            end
            if (intrude && i == 3) begin
                #1;
                start = 1'b1; a = 16'd5; b = 16'd1; signed_mode = 1'b0;
            end
        end
        if (!got) chk({nm, "_timeout"}, 32'd1, 32'd0);
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_quotient"}, 32'(quotient), 32'(eq));
        chk({nm, "_remainder"}, 32'(remainder), 32'(er));
        chk({nm, "_flags_dbzZNV"}, 32'({dbz, Z, N, V}), 32'(eflags));
        chk({nm, "_C"}, 32'(C), 32'd0);
    endtask

    initial begin
        int dn;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_ctrl_busy_done_dbzZNV", 32'({busy, done, dbz, Z, N, V}), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;

        run_lit("unsigned_100_7", 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 4'b0000, W + 2, 1'b0);
        run_lit("signed_m100_7", 16'hFF9C, 16'd7, 1'b1, 16'hFFF2, 16'hFFFE, 4'b0010, W + 2, 1'b0);
        run_lit("div_by_zero", 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 4'b1011, 2, 1'b0);
        run_lit("signed_ovf", 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 4'b0011, 2, 1'b0);
        run_lit("early_3_10", 16'd3, 16'd10, 1'b0, 16'd0, 16'd3, 4'b0100, ET_LAT, 1'b0);
        run_lit("busy_ignore", 16'd1000, 16'd3, 1'b0, 16'd333, 16'd1, 4'b0000, W + 2, 1'b1);

        // Start raised during the done cycle: dropped, then taken a cycle later.
        run_lit("signed_m7_m2", 16'hFFF9, 16'hFFFE, 1'b1, 16'd3, 16'hFFFF, 4'b0000, W + 2, 1'b0);
        #1;
        start = 1'b1; a = 16'd50; b = 16'd5; signed_mode = 1'b0;
        @(posedge clk); #1;
        chk("start_on_done_ignored_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("start_after_done_accepted_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_idle();
        chk("start_after_done_quotient", 32'(quotient), 32'd10);

        // Reset in the middle of an operation.
        @(posedge clk); #2;
        start = 1'b1; a = 16'd999; b = 16'd4; signed_mode = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midop_reset_quotient", 32'(quotient), 32'd0);
        chk("midop_reset_remainder", 32'(remainder), 32'd0);
        chk("midop_reset_ctrl", 32'({busy, done, dbz, Z, N, V}), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        dn = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chk("midop_reset_no_done", 32'(dn), 32'd0);

        // Random start traffic, including starts while busy and on done cycles.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if (start) begin
                if ($urandom_range(0, 1) == 0) start = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                start       = 1'b1;
                signed_mode = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 5))
                    0: begin a = 16'($urandom); b = 16'h0000; end
                    1: begin a = MINV; b = 16'hFFFF; end
                    2: begin a = 16'($urandom); b = 16'($urandom_range(1, 15)); end
                    3: begin a = 16'($urandom_range(0, 40)); b = 16'($urandom); end
                    4: begin a = 16'($urandom); b = {12'hFFF, 4'($urandom)}; end
                    default: begin a = 16'($urandom); b = 16'($urandom); end
                endcase
            end
        end
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
